// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with a direct-mapped branch target buffer.
// The BTB is read combinationally from PC_F. A write lands at the clock
// edge, so a same-cycle read of the written slot still sees the old entry.
// Next-PC priority: redirect_E > stall_F > predicted-taken > PC_F + 4.
// Each valid bit has an async reset. The tag and target arrays are not
// reset, because an entry is ignored until its valid bit is set.
module fetch_pc_gen #(
    parameter int          INDEX_BITS = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        predict_taken_F,
    input  logic        redirect_E,
    input  logic [31:0] redirect_pc_E,
    input  logic        btb_update_en,
    input  logic [31:0] btb_pc_E,
    input  logic [31:0] btb_target_E,
    output logic [31:0] PC_F,
    output logic [31:0] PCPlus4_F,
    output logic        btb_hit_F,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [31:0]           pc_q;
    logic [31:0]           next_pc;
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [29:0]           target_q [ENTRIES];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [TAG_BITS-1:0]   wr_tag;

    // Word-alignment bits of incoming addresses are dropped by design.
    logic unused_low_bits;
    assign unused_low_bits = ^{redirect_pc_E[1:0], btb_pc_E[1:0], btb_target_E[1:0]};

    assign rd_idx = pc_q[INDEX_BITS+1:2];
    assign rd_tag = pc_q[31:INDEX_BITS+2];
    assign wr_idx = btb_pc_E[INDEX_BITS+1:2];
    assign wr_tag = btb_pc_E[31:INDEX_BITS+2];

    assign PC_F          = pc_q;
    assign PCPlus4_F     = pc_q + 32'd4;
    assign btb_hit_F     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken_F  = btb_hit_F && predict_taken_F;
    assign pred_target_F = {target_q[rd_idx], 2'b00};

    // Next-PC selection: redirect overrides stall, stall overrides prediction.
    always_comb begin
        next_pc = PCPlus4_F;
        if (redirect_E) begin
            next_pc = {redirect_pc_E[31:2], 2'b00};
        end else if (stall_F) begin
            next_pc = pc_q;
        end else if (pred_taken_F) begin
            next_pc = pred_target_F;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    // BTB valid bits: cleared on reset, set by a training write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (btb_update_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // BTB tag/target storage. A write always replaces the slot at its index.
    always_ff @(posedge clk) begin
        if (btb_update_en && rst) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= btb_target_E[31:2];
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed steps followed by random traffic.
// The reference model keeps each BTB entry as the full branch PC plus its
// aligned target. It checks the PC sequence and the BTB outputs each cycle.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_F = 1'b0;
    logic        predict_taken_F = 1'b0;
    logic        redirect_E = 1'b0;
    logic [31:0] redirect_pc_E = '0;
    logic        btb_update_en = 1'b0;
    logic [31:0] btb_pc_E = '0;
    logic [31:0] btb_target_E = '0;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;
    logic        btb_hit_F;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    bit          m_valid [16];
    logic [31:0] m_bpc   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] exp_q[$];

    fetch_pc_gen #(.INDEX_BITS(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_F         (stall_F),
        .predict_taken_F (predict_taken_F),
        .redirect_E      (redirect_E),
        .redirect_pc_E   (redirect_pc_E),
        .btb_update_en   (btb_update_en),
        .btb_pc_E        (btb_pc_E),
        .btb_target_E    (btb_target_E),
        .PC_F            (PC_F),
        .PCPlus4_F       (PCPlus4_F),
        .btb_hit_F       (btb_hit_F),
        .pred_taken_F    (pred_taken_F),
        .pred_target_F   (pred_target_F)
    );

    // Clock generation.
    always #5 clk = ~clk;

    function automatic int slot(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_bpc[slot(a)][31:6] == a[31:6]);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Compare all outputs against the model at the current PC.
    task automatic check_all(input string name);
        bit h;
        h = m_hit(m_pc);
        chk({name, "/pc"}, PC_F, m_pc);
        chk({name, "/pc4"}, PCPlus4_F, m_pc + 32'd4);
        chk({name, "/hit"}, {31'd0, btb_hit_F}, {31'd0, h});
        chk({name, "/ptk"}, {31'd0, pred_taken_F}, {31'd0, h & predict_taken_F});
        if (h) chk({name, "/tgt"}, pred_target_F, m_tgt[slot(m_pc)]);
    endtask

    // Apply one set of inputs across a rising edge and advance the model.
    task automatic do_cycle(input bit st, input bit pt, input bit rd, input logic [31:0] rpc,
                            input bit up, input logic [31:0] bpc, input logic [31:0] btg);
        logic [31:0] nxt;
        stall_F = st; predict_taken_F = pt; redirect_E = rd; redirect_pc_E = rpc;
        btb_update_en = up; btb_pc_E = bpc; btb_target_E = btg;
        if (rd)                        nxt = {rpc[31:2], 2'b00};
        else if (st)                   nxt = m_pc;
        else if (pt && m_hit(m_pc))    nxt = m_tgt[slot(m_pc)];
        else                           nxt = m_pc + 32'd4;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        if (up) begin
            m_valid[slot(bpc)] = 1'b1;
            m_bpc[slot(bpc)]   = bpc;
            m_tgt[slot(bpc)]   = {btg[31:2], 2'b00};
        end
        m_pc = exp_q.pop_front();
        predict_taken_F = 1'b0; btb_update_en = 1'b0; redirect_E = 1'b0; stall_F = 1'b0;
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] a);
        do_cycle(0, 0, 1, a, 0, 32'h0, 32'h0);
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Assert reset between edges, check immediately, release on the falling edge.
    task automatic async_reset(input string name);
        stall_F = 0; predict_taken_F = 0; redirect_E = 0; btb_update_en = 0;
        #2 rst = 1'b0;
        #1 model_reset();
        check_all(name);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_bpc[i] = '0; m_tgt[i] = '0;
        end
        model_reset();

        // Reset state and free-running sequence.
        #3;
        check_all("reset");
        chk("reset_pc4", PCPlus4_F, 32'd4);
        @(negedge clk);
        rst = 1'b1;
        idle(); chk("seq4", PC_F, 32'd4);
        idle(); chk("seq8", PC_F, 32'd8);
        idle(); chk("seq12", PC_F, 32'd12);

        // Train 0x40 -> 0x100, then predict taken and not taken.
        do_cycle(0, 0, 0, 32'h0, 1, 32'h40, 32'h100); check_all("train");
        jump(32'h40); predict_taken_F = 1'b1; #1;
        check_all("at40");
        chk("hit40", {31'd0, btb_hit_F}, 32'd1);
        chk("tgt40", pred_target_F, 32'h100);
        do_cycle(0, 1, 0, 32'h0, 0, 32'h0, 32'h0); chk("taken", PC_F, 32'h100);
        jump(32'h40);
        do_cycle(0, 0, 0, 32'h0, 0, 32'h0, 32'h0); chk("not_taken", PC_F, 32'h44);

        // Priority: redirect beats stall and prediction; stall beats prediction.
        jump(32'h40);
        do_cycle(1, 1, 1, 32'h1003, 0, 32'h0, 32'h0); chk("prio_redir", PC_F, 32'h1000);
        jump(32'h40);
        do_cycle(1, 1, 0, 32'h0, 0, 32'h0, 32'h0); chk("prio_stall", PC_F, 32'h40);

        // Alias: same index, different tag.
        jump(32'h80);
        chk("alias_miss", {31'd0, btb_hit_F}, 32'd0);
        do_cycle(0, 1, 0, 32'h0, 0, 32'h0, 32'h0); chk("alias_next", PC_F, 32'h84);
        do_cycle(0, 0, 0, 32'h0, 1, 32'h80, 32'h200); check_all("retrain");
        jump(32'h40);
        chk("evicted", {31'd0, btb_hit_F}, 32'd0);

        // Async reset clears the BTB.
        async_reset("async_rst");
        jump(32'h80);
        chk("rst_miss", {31'd0, btb_hit_F}, 32'd0);

        // Same-cycle write/read with stall.
        jump(32'h40);
        stall_F = 1'b1; btb_update_en = 1'b1; btb_pc_E = 32'h40; btb_target_E = 32'h300; #1;
        chk("wr_old", {31'd0, btb_hit_F}, 32'd0);
        do_cycle(1, 0, 0, 32'h0, 1, 32'h40, 32'h300);
        chk("wr_new_hit", {31'd0, btb_hit_F}, 32'd1);
        chk("wr_new_tgt", pred_target_F, 32'h300);
        chk("wr_hold", PC_F, 32'h40);

        // Redirect and write together: the fetch sees the new entry.
        do_cycle(0, 0, 1, 32'h1C0, 1, 32'h1C0, 32'h2003); check_all("redir_wr");
        chk("redir_wr_hit", {31'd0, btb_hit_F}, 32'd1);

        // Wrap-around.
        jump(32'hFFFF_FFFC);
        idle(); chk("wrap", PC_F, 32'h0);

        // Random traffic over a small address window so the BTB aliases often.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc, bpc, btg;
            rpc = {24'd0, 8'($urandom_range(0, 255))};
            bpc = {23'd0, 9'($urandom_range(0, 511))};
            btg = {24'd0, 8'($urandom_range(0, 255))};
            if (n == 200) async_reset("rand_rst");
            do_cycle(($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 7) == 0), rpc,
                     ($urandom_range(0, 2) == 0), bpc, btg);
            predict_taken_F = $urandom_range(0, 1) == 1;
            #1;
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
